// File: rtl/elevador_req_input_pkg.sv
// Board-level constants shared by the elevator input stage, the controller and the top level.
// Keeping floor count and index width here guarantees that every block agrees on them.
package elevador_req_input_pkg;

    localparam int DEF_N_FLOORS        = 5;
    localparam int DEF_FLOOR_W         = 3;
    localparam int DEF_DEBOUNCE_CYCLES = 500000;  // 10 ms at 50 MHz
    localparam int DEF_CNT_W           = 19;

    // Conditioned inputs are packed as {sw_exit, sw_enter, sw_floor}.
    localparam int N_EXTRA_INPUTS = 2;

    function automatic int n_inputs(input int n_floors);
        return n_floors + N_EXTRA_INPUTS;
    endfunction

    function automatic int idx_enter(input int n_floors);
        return n_floors;
    endfunction

    function automatic int idx_exit(input int n_floors);
        return n_floors + 1;
    endfunction

endpackage

// File: rtl/elevador_debounce.sv
// One switch channel: 2-FF synchroniser, hold-time debouncer and rising-edge detector.
// A new level is accepted only after it has been seen continuously for DEBOUNCE_CYCLES cycles.
module elevador_debounce
    import elevador_req_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic stable,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_stable_d;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
        end
    end

    // Any return to the accepted level restarts the hold window, so bounces never leak through.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (r_sync2 == r_stable) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stable_d <= 1'b0;
        end else begin
            r_stable_d <= r_stable;
        end
    end

    assign stable = r_stable;
    assign rise   = r_stable & ~r_stable_d;

endmodule

// File: rtl/elevador_req_input.sv
// Elevator input conditioning: debounced floor/passenger switches, sticky per-floor requests
// cleared by the controller, and single-cycle enter/exit pulses.
module elevador_req_input
    import elevador_req_input_pkg::*;
#(
    parameter int N_FLOORS        = DEF_N_FLOORS,
    parameter int FLOOR_W         = DEF_FLOOR_W,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_FLOORS-1:0]          sw_floor,
    input  logic                         sw_enter,
    input  logic                         sw_exit,
    // served_valid is a one-cycle strobe with no back-pressure: the clear is taken the cycle it is seen.
    input  logic                         served_valid,
    input  logic [FLOOR_W-1:0]           served_floor,
    output logic [N_FLOORS-1:0]          req_pending,
    output logic                         req_any,
    output logic                         enter_pulse,
    output logic                         exit_pulse,
    output logic [N_FLOORS+1:0]          dbg_stable
);

    localparam int N_IN  = n_inputs(N_FLOORS);
    localparam int I_ENT = idx_enter(N_FLOORS);
    localparam int I_EXT = idx_exit(N_FLOORS);

    logic [N_IN-1:0]     w_raw;
    logic [N_IN-1:0]     w_stable;
    logic [N_IN-1:0]     w_rise;
    logic [N_FLOORS-1:0] w_clr;

    logic [N_FLOORS-1:0] r_req_pending;
    logic                r_enter_pulse;
    logic                r_exit_pulse;

    assign w_raw = {sw_exit, sw_enter, sw_floor};

    genvar g;
    generate
        for (g = 0; g < N_IN; g++) begin : g_deb
            elevador_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_deb (
                .clk    (clk),
                .reset  (reset),
                .din    (w_raw[g]),
                .stable (w_stable[g]),
                .rise   (w_rise[g])
            );
        end

        // Out-of-range floor indices match no bit, so they are ignored for free.
        for (g = 0; g < N_FLOORS; g++) begin : g_clr
            localparam logic [FLOOR_W-1:0] FLOOR_IDX = FLOOR_W'(g);
            assign w_clr[g] = served_valid && (served_floor == FLOOR_IDX);
        end
    endgenerate

    // Clear beats a same-cycle rise; a held switch cannot re-request without a new debounced edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req_pending <= '0;
        end else begin
            for (int i = 0; i < N_FLOORS; i++) begin
                if (w_clr[i]) begin
                    r_req_pending[i] <= 1'b0;
                end else if (w_rise[i]) begin
                    r_req_pending[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_enter_pulse <= 1'b0;
            r_exit_pulse  <= 1'b0;
        end else begin
            r_enter_pulse <= w_rise[I_ENT];
            r_exit_pulse  <= w_rise[I_EXT];
        end
    end

    assign req_pending = r_req_pending;
    assign req_any     = |r_req_pending;
    assign enter_pulse = r_enter_pulse;
    assign exit_pulse  = r_exit_pulse;
    assign dbg_stable  = w_stable;

endmodule

// File: tb/tb_elevador_req_input.sv
// Directed bench for elevador_req_input with a short debounce window (4 cycles).
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
module tb_elevador_req_input;

    localparam int NF  = 5;
    localparam int FW  = 3;
    localparam int DEB = 4;
    localparam int CW  = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [NF-1:0] sw_floor;
    logic          sw_enter;
    logic          sw_exit;
    logic          served_valid;
    logic [FW-1:0] served_floor;
    logic [NF-1:0] req_pending;
    logic          req_any;
    logic          enter_pulse;
    logic          exit_pulse;
    logic [NF+1:0] dbg_stable;

    int n_checks = 0;
    int n_errors = 0;
    logic [NF-1:0] exp_q[$];

    elevador_req_input #(
        .N_FLOORS        (NF),
        .FLOOR_W         (FW),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sw_floor     (sw_floor),
        .sw_enter     (sw_enter),
        .sw_exit      (sw_exit),
        .served_valid (served_valid),
        .served_floor (served_floor),
        .req_pending  (req_pending),
        .req_any      (req_any),
        .enter_pulse  (enter_pulse),
        .exit_pulse   (exit_pulse),
        .dbg_stable   (dbg_stable)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic serve(input logic [FW-1:0] f);
        served_valid = 1'b1;
        served_floor = f;
        tick();
        served_valid = 1'b0;
        served_floor = '0;
    endtask

    task automatic serve_step(input logic v, input logic [FW-1:0] f, input logic [NF-1:0] exp);
        exp_q.push_back(exp);
        served_valid = v;
        served_floor = f;
        tick();
        served_valid = 1'b0;
        served_floor = '0;
        check("serve_step", 32'(req_pending), 32'(exp_q.pop_front()));
    endtask

    int n_ent, n_ex, ent_at, ex_at;

    initial begin
        reset        = 1'b1;
        sw_floor     = '0;
        sw_enter     = 1'b0;
        sw_exit      = 1'b0;
        served_valid = 1'b0;
        served_floor = '0;
        repeat (3) tick();
        check("rst_init_pending", 32'(req_pending), 32'h0);
        check("rst_init_any", 32'(req_any), 32'h0);
        check("rst_init_pulses", 32'({enter_pulse, exit_pulse}), 32'h0);
        reset = 1'b0;

        // Build up pending state, then reset asynchronously mid-cycle.
        sw_floor = 5'b10101;
        repeat (7) tick();
        check("pre_rst_pending", 32'(req_pending), 32'h15);
        check("pre_rst_any", 32'(req_any), 32'h1);
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_pending", 32'(req_pending), 32'h0);
        check("async_rst_any", 32'(req_any), 32'h0);
        check("async_rst_stable", 32'(dbg_stable), 32'h0);
        check("async_rst_pulses", 32'({enter_pulse, exit_pulse}), 32'h0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (6) tick();
        check("rst_redeb_early", 32'(req_pending), 32'h0);
        tick();
        check("rst_redeb_pending", 32'(req_pending), 32'h15);

        sw_floor = '0;
        serve(3'd0);
        serve(3'd2);
        serve(3'd4);
        check("cleanup_pending", 32'(req_pending), 32'h0);
        repeat (8) tick();
        check("cleanup_stable", 32'(dbg_stable), 32'h0);

        // Bounce rejection: two 3-cycle bursts are shorter than the hold window.
        sw_floor[2] = 1'b1; repeat (3) tick();
        sw_floor[2] = 1'b0; repeat (2) tick();
        sw_floor[2] = 1'b1; repeat (3) tick();
        sw_floor[2] = 1'b0; repeat (10) tick();
        check("bounce_pending", 32'(req_pending), 32'h0);
        check("bounce_stable", 32'(dbg_stable), 32'h0);
        sw_floor[2] = 1'b1;
        repeat (10) tick();
        check("hold_pending", 32'(req_pending), 32'h04);
        check("hold_any", 32'(req_any), 32'h1);
        sw_floor[2] = 1'b0;
        repeat (8) tick();
        serve(3'd2);
        check("serve2_pending", 32'(req_pending), 32'h0);

        // Two floors requested in the same cycle.
        sw_floor = 5'b01010;
        repeat (10) tick();
        check("multi_set", 32'(req_pending), 32'h0A);
        sw_floor = '0;
        repeat (8) tick();
        sw_floor[1] = 1'b1;
        repeat (10) tick();
        check("rise_on_pending", 32'(req_pending), 32'h0A);
        sw_floor[1] = 1'b0;
        repeat (8) tick();

        // scoreboard of clear steps
        serve_step(1'b1, 3'd3, 5'b00010);
        serve_step(1'b1, 3'd6, 5'b00010);
        serve_step(1'b1, 3'd7, 5'b00010);
        serve_step(1'b1, 3'd4, 5'b00010);
        serve_step(1'b0, 3'd1, 5'b00010);
        serve_step(1'b1, 3'd1, 5'b00000);
        check("serve_any_zero", 32'(req_any), 32'h0);

        // Clear lands in the same cycle as the floor-0 rise.
        sw_floor[0] = 1'b1;
        repeat (6) tick();
        serve(3'd0);
        check("collide_pending", 32'(req_pending), 32'h0);
        repeat (10) tick();
        check("held_no_rereq", 32'(req_pending), 32'h0);
        sw_floor[0] = 1'b0;
        repeat (8) tick();
        check("released_pending", 32'(req_pending), 32'h0);
        sw_floor[0] = 1'b1;
        repeat (7) tick();
        check("repress_pending", 32'(req_pending), 32'h01);
        sw_floor[0] = 1'b0;
        serve(3'd0);
        repeat (8) tick();

        // Passenger pulses.
        n_ent = 0; n_ex = 0; ent_at = 0; ex_at = 0;
        sw_enter = 1'b1;
        sw_exit  = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (enter_pulse) begin n_ent++; ent_at = c; end
            if (exit_pulse)  begin n_ex++;  ex_at  = c; end
        end
        check("enter_count", 32'(n_ent), 32'd1);
        check("exit_count", 32'(n_ex), 32'd1);
        check("enter_cycle", 32'(ent_at), 32'd7);
        check("exit_cycle", 32'(ex_at), 32'd7);
        check("pass_no_req", 32'(req_pending), 32'h0);
        n_ent = 0; n_ex = 0;
        sw_enter = 1'b0;
        sw_exit  = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (enter_pulse) n_ent++;
            if (exit_pulse)  n_ex++;
        end
        check("release_enter", 32'(n_ent), 32'd0);
        check("release_exit", 32'(n_ex), 32'd0);

        // final report
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
